// File: rtl/mccu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU functions, next-PC and write-register selects, decoded instruction class.
package mccu_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b100110;
    localparam logic [5:0] OP_LW    = 6'b100111;
    localparam logic [5:0] OP_BEQ   = 6'b110000;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_IF      = 4'b0000,
        S_ID      = 4'b0001,
        S_EXE_MEM = 4'b0010,
        S_MEM     = 4'b0011,
        S_WB_LD   = 4'b0100,
        S_EXE_BR  = 4'b0101,
        S_EXE_AL  = 4'b0110,
        S_WB_AL   = 4'b0111,
        S_HALT    = 4'b1000
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_BEQ,
        CLS_BNE,
        CLS_LW,
        CLS_SW,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_HALT
    } inst_class_t;

    typedef struct packed {
        inst_class_t cls;
        logic [2:0]  alu_op;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        ext_sel;
        logic [1:0]  reg_dst;
    } decode_t;

endpackage

// File: rtl/mccu_decode.sv
// Combinational per-opcode select table and instruction classifier.
// JAL/JR are recognised only when MCCU_JAL_JR_EN is defined.
module mccu_decode
    import mccu_pkg::*;
(
    input  logic [5:0] op,
    output decode_t    dec
);

    always_comb begin
        dec.cls       = CLS_NOP;
        dec.alu_op    = ALU_ADD;
        dec.alu_src_a = 1'b0;
        dec.alu_src_b = 1'b0;
        dec.ext_sel   = 1'b1;
        dec.reg_dst   = REG_DST_RT;
        case (op)
            OP_ADD: begin
                dec.cls     = CLS_ALU;
                dec.reg_dst = REG_DST_RD;
            end
            OP_SUB: begin
                dec.cls     = CLS_ALU;
                dec.alu_op  = ALU_SUB;
                dec.reg_dst = REG_DST_RD;
            end
            OP_ADDIU: begin
                dec.cls       = CLS_ALU;
                dec.alu_src_b = 1'b1;
            end
            OP_ANDI: begin
                dec.cls       = CLS_ALU;
                dec.alu_op    = ALU_AND;
                dec.alu_src_b = 1'b1;
                dec.ext_sel   = 1'b0;
            end
            OP_AND: begin
                dec.cls     = CLS_ALU;
                dec.alu_op  = ALU_AND;
                dec.reg_dst = REG_DST_RD;
            end
            OP_ORI: begin
                dec.cls       = CLS_ALU;
                dec.alu_op    = ALU_OR;
                dec.alu_src_b = 1'b1;
                dec.ext_sel   = 1'b0;
            end
            OP_OR: begin
                dec.cls     = CLS_ALU;
                dec.alu_op  = ALU_OR;
                dec.reg_dst = REG_DST_RD;
            end
            OP_SLL: begin
                dec.cls       = CLS_ALU;
                dec.alu_op    = ALU_SLL;
                dec.alu_src_a = 1'b1;
                dec.reg_dst   = REG_DST_RD;
            end
            OP_SLTI: begin
                dec.cls       = CLS_ALU;
                dec.alu_op    = ALU_SLT;
                dec.alu_src_b = 1'b1;
            end
            OP_SW: begin
                dec.cls       = CLS_SW;
                dec.alu_src_b = 1'b1;
            end
            OP_LW: begin
                dec.cls       = CLS_LW;
                dec.alu_src_b = 1'b1;
            end
            OP_BEQ: begin
                dec.cls    = CLS_BEQ;
                dec.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                dec.cls    = CLS_BNE;
                dec.alu_op = ALU_SUB;
            end
            OP_J:    dec.cls = CLS_J;
            OP_HALT: dec.cls = CLS_HALT;
`ifdef MCCU_JAL_JR_EN
            OP_JAL: begin
                dec.cls     = CLS_JAL;
                dec.reg_dst = REG_DST_RA;
            end
            OP_JR:   dec.cls = CLS_JR;
`endif
            default: dec.cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle IF/ID/EXE/MEM/WB control sequencer with Moore strobes.
// Optional JAL/JR support is enabled by defining MCCU_JAL_JR_EN.
module multi_cycle_control_unit
    import mccu_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [5:0]         OpCode,
    input  logic               zero,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               ExtSel,
    output logic [1:0]         RegDst,
    output logic               WrRegDSrc,
    output logic               DBDataSrc,
    output logic               RegWre,
    output logic               RD,
    output logic               WR,
    output logic [1:0]         PCSrc,
    output logic [STATE_W-1:0] State
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic [5:0] op_eff;
    decode_t    dec;

    // IR is stable during ID, so decode the live opcode there; later states use the copy taken in ID.
    assign op_eff = (state_q == S_ID) ? OpCode : op_q;

    mccu_decode u_decode (
        .op  (op_eff),
        .dec (dec)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IF;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                op_q <= OpCode;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        IRWre     = 1'b0;
        PCWre     = 1'b0;
        RegWre    = 1'b0;
        RD        = 1'b1;
        WR        = 1'b1;
        InsMemRW  = 1'b1;
        PCSrc     = PC_NEXT;
        ALUOp     = ALU_ADD;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b1;
        RegDst    = REG_DST_RT;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b0;

        if (state_q != S_IF && state_q != S_HALT) begin
            ALUOp     = dec.alu_op;
            ALUSrcA   = dec.alu_src_a;
            ALUSrcB   = dec.alu_src_b;
            ExtSel    = dec.ext_sel;
            RegDst    = dec.reg_dst;
            DBDataSrc = (dec.cls == CLS_LW);
        end

        case (state_q)
            S_IF: begin
                IRWre   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (dec.cls)
                    CLS_ALU:          state_d = S_EXE_AL;
                    CLS_BEQ, CLS_BNE: state_d = S_EXE_BR;
                    CLS_LW, CLS_SW:   state_d = S_EXE_MEM;
                    CLS_HALT:         state_d = S_HALT;
                    CLS_J: begin
                        PCWre   = 1'b1;
                        PCSrc   = PC_JUMP;
                        state_d = S_IF;
                    end
`ifdef MCCU_JAL_JR_EN
                    CLS_JAL: begin
                        PCWre     = 1'b1;
                        PCSrc     = PC_JUMP;
                        RegWre    = 1'b1;
                        WrRegDSrc = 1'b0;
                        state_d   = S_IF;
                    end
                    CLS_JR: begin
                        PCWre   = 1'b1;
                        PCSrc   = PC_REG;
                        state_d = S_IF;
                    end
`endif
                    default: begin
                        PCWre   = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL: begin
                RegWre  = 1'b1;
                PCWre   = 1'b1;
                state_d = S_IF;
            end
            S_EXE_BR: begin
                PCWre   = 1'b1;
                if ((dec.cls == CLS_BEQ && zero) || (dec.cls == CLS_BNE && !zero)) begin
                    PCSrc = PC_BRANCH;
                end
                state_d = S_IF;
            end
            S_EXE_MEM: state_d = S_MEM;
            S_MEM: begin
                if (dec.cls == CLS_LW) begin
                    RD      = 1'b0;
                    state_d = S_WB_LD;
                end else begin
                    WR      = 1'b0;
                    PCWre   = 1'b1;
                    state_d = S_IF;
                end
            end
            S_WB_LD: begin
                RegWre  = 1'b1;
                PCWre   = 1'b1;
                state_d = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    assign State = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed self-checking bench for multi_cycle_control_unit; JAL/JR
// expectations follow MCCU_JAL_JR_EN.
module tb_multi_cycle_control_unit;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] OpCode = '0;
    logic       zero = 1'b0;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
    logic       WrRegDSrc, DBDataSrc, RegWre, RD, WR;
    logic [2:0] ALUOp;
    logic [1:0] RegDst, PCSrc;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multi_cycle_control_unit #(.STATE_W(4)) dut (
        .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .RegWre(RegWre), .RD(RD), .WR(WR), .PCSrc(PCSrc), .State(State)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if ({State, IRWre, PCWre, RegWre, RD, WR, InsMemRW, PCSrc} !== {4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=%b", {State, IRWre, PCWre, RegWre, RD, WR, InsMemRW, PCSrc}, 11'b0000_1001_1_1_00);
        end
        checks++;
        if ({ALUOp, ALUSrcA, ALUSrcB, ExtSel, RegDst, WrRegDSrc, DBDataSrc} !== {3'b000, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_selects got=%b exp=%b", {ALUOp, ALUSrcA, ALUSrcB, ExtSel, RegDst, WrRegDSrc, DBDataSrc}, 10'b000_0_0_1_00_1_0);
        end
    endtask

    task automatic test_add;
        logic [3:0] st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        OpCode = 6'b000000;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if ({State, IRWre, RegWre, PCWre} !== {st[i], (i == 0 || i == 4), (i == 3), (i == 3)}) begin
                errors++;
                $display("FAIL add_cycle%0d got=%b exp=%b", i, {State, IRWre, RegWre, PCWre}, {st[i], (i == 0 || i == 4), (i == 3), (i == 3)});
            end
            if (i == 3) begin
                checks++;
                if ({RegDst, ALUOp} !== {2'b01, 3'b000}) begin
                    errors++;
                    $display("FAIL add_selects got=%b exp=%b", {RegDst, ALUOp}, 5'b01_000);
                end
            end
        end
    endtask

    task automatic test_imm_sll;
        logic [5:0] ops [2] = '{6'b010010, 6'b011000};
        logic [7:0] sel [2] = '{8'b011_0_1_0_00, 8'b010_1_0_1_01};
        for (int k = 0; k < 2; k++) begin
            OpCode = ops[k];
            tick();
            tick();
            checks++;
            if ({State, ALUOp, ALUSrcA, ALUSrcB, ExtSel, RegDst} !== {4'd6, sel[k]}) begin
                errors++;
                $display("FAIL imm_sll_exe%0d got=%b exp=%b", k, {State, ALUOp, ALUSrcA, ALUSrcB, ExtSel, RegDst}, {4'd6, sel[k]});
            end
            tick();
            tick();
        end
    endtask

    task automatic test_lw;
        logic [3:0] st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        OpCode = 6'b100111;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if ({State, RD, WR, RegWre, PCWre} !== {st[i], (i != 3), 1'b1, (i == 4), (i == 4)}) begin
                errors++;
                $display("FAIL lw_cycle%0d got=%b exp=%b", i, {State, RD, WR, RegWre, PCWre}, {st[i], (i != 3), 1'b1, (i == 4), (i == 4)});
            end
            if (i == 4) begin
                checks++;
                if ({DBDataSrc, ALUSrcB, RegDst} !== {1'b1, 1'b1, 2'b00}) begin
                    errors++;
                    $display("FAIL lw_wb_selects got=%b exp=%b", {DBDataSrc, ALUSrcB, RegDst}, 4'b1100);
                end
            end
            // IR changes after ID must not redirect the running load
            if (i == 2) OpCode = 6'b100110;
        end
    endtask

    task automatic test_sw;
        logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        OpCode = 6'b100110;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if ({State, RD, WR, RegWre, PCWre} !== {st[i], 1'b1, (i != 3), 1'b0, (i == 3)}) begin
                errors++;
                $display("FAIL sw_cycle%0d got=%b exp=%b", i, {State, RD, WR, RegWre, PCWre}, {st[i], 1'b1, (i != 3), 1'b0, (i == 3)});
            end
        end
    endtask

    task automatic test_branch;
        logic [5:0] ops [3] = '{6'b110000, 6'b110000, 6'b110001};
        logic       zs  [3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0] src [3] = '{2'b01, 2'b00, 2'b00};
        for (int k = 0; k < 3; k++) begin
            OpCode = ops[k];
            zero = zs[k];
            tick();
            tick();
            checks++;
            if ({State, PCSrc, PCWre, ALUOp, RegWre} !== {4'd5, src[k], 1'b1, 3'b001, 1'b0}) begin
                errors++;
                $display("FAIL branch%0d_exe got=%b exp=%b", k, {State, PCSrc, PCWre, ALUOp, RegWre}, {4'd5, src[k], 1'b1, 3'b001, 1'b0});
            end
            if (k == 1) begin
                zero = 1'b1;
                #1;
                checks++;
                if (PCSrc !== 2'b01) begin
                    errors++;
                    $display("FAIL beq_zero_live got=%b exp=01", PCSrc);
                end
            end
            tick();
            checks++;
            if (State !== 4'd0) begin
                errors++;
                $display("FAIL branch%0d_return got=%h exp=0", k, State);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump_nop;
        logic [5:0] ops [2] = '{6'b111000, 6'b000111};
        logic [1:0] src [2] = '{2'b10, 2'b00};
        for (int k = 0; k < 2; k++) begin
            OpCode = ops[k];
            tick();
            checks++;
            if ({State, PCWre, PCSrc, RegWre} !== {4'd1, 1'b1, src[k], 1'b0}) begin
                errors++;
                $display("FAIL jump_nop%0d_id got=%b exp=%b", k, {State, PCWre, PCSrc, RegWre}, {4'd1, 1'b1, src[k], 1'b0});
            end
            tick();
            checks++;
            if ({State, IRWre} !== {4'd0, 1'b1}) begin
                errors++;
                $display("FAIL jump_nop%0d_return got=%b exp=00001", k, {State, IRWre});
            end
        end
    endtask

    task automatic test_jal_jr;
        logic [5:0] ops [2] = '{6'b111010, 6'b111001};
`ifdef MCCU_JAL_JR_EN
        logic [6:0] exp [2] = '{7'b10_0_1_10_1, 7'b00_1_0_11_1};
`else
        logic [6:0] exp [2] = '{7'b00_1_0_00_1, 7'b00_1_0_00_1};
`endif
        for (int k = 0; k < 2; k++) begin
            OpCode = ops[k];
            tick();
            checks++;
            if ({State, RegDst, WrRegDSrc, RegWre, PCSrc, PCWre} !== {4'd1, exp[k]}) begin
                errors++;
                $display("FAIL jal_jr%0d_id got=%b exp=%b", k, {State, RegDst, WrRegDSrc, RegWre, PCSrc, PCWre}, {4'd1, exp[k]});
            end
            tick();
            checks++;
            if (State !== 4'd0) begin
                errors++;
                $display("FAIL jal_jr%0d_return got=%h exp=0", k, State);
            end
        end
    endtask

    task automatic test_reset_mid;
        OpCode = 6'b000000;
        tick();
        tick();
        tick();
        checks++;
        if ({State, RegWre} !== {4'd7, 1'b1}) begin
            errors++;
            $display("FAIL mid_wb_al got=%b exp=01111", {State, RegWre});
        end
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if ({State, IRWre, RegWre, PCWre} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=0000100", {State, IRWre, RegWre, PCWre});
        end
    endtask

    task automatic test_halt;
        int bad = 0;
        OpCode = 6'b111111;
        tick();
        tick();
        OpCode = 6'b000000;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({State, PCWre, IRWre, RegWre, RD, WR} !== {4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                bad++;
                if (bad < 4) $display("FAIL halt_hold%0d got=%b exp=100000011", i, {State, PCWre, IRWre, RegWre, RD, WR});
            end
            tick();
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if ({State, IRWre} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL halt_reset got=%b exp=00001", {State, IRWre});
        end
        tick();
        checks++;
        if (State !== 4'd1) begin
            errors++;
            $display("FAIL halt_recover got=%h exp=1", State);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm_sll();
        test_lw();
        test_sw();
        test_branch();
        test_jump_nop();
        test_jal_jr();
        test_reset_mid();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
